// File: rtl/ccr_stack_unit.sv
// Condition-code register with per-bit flag forwarding and a LIFO flag-save stack.
// Define CCR_STACK_STICKY_ERR_EN for sticky ovf/unf errors cleared by err_clr.
module ccr_stack_unit #(
  parameter int unsigned FLAG_W = 4,
  parameter int unsigned N_FWD  = 2,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_FWD*FLAG_W-1:0]      fwd_flags,
  input  logic [N_FWD*FLAG_W-1:0]      fwd_mask,
  input  logic [FLAG_W-1:0]            wb_flags,
  input  logic [FLAG_W-1:0]            wb_mask,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         err_clr,
  output logic [FLAG_W-1:0]            ccr_reg,
  output logic [FLAG_W-1:0]            current_flags,
  output logic [$clog2(DEPTH+1)-1:0]   depth_cnt,
  output logic                         stack_full,
  output logic                         stack_empty,
  output logic                         ovf_err,
  output logic                         unf_err
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [FLAG_W-1:0] stack_mem [DEPTH];
  logic [FLAG_W-1:0] merged;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              do_push;
  logic              do_pop;
  logic              ovf_evt;
  logic              unf_evt;

  assign stack_full  = (depth_cnt == CNT_W'(DEPTH));
  assign stack_empty = (depth_cnt == '0);
  assign merged      = (ccr_reg & ~wb_mask) | (wb_flags & wb_mask);

  // Simultaneous push and pop cancel out: no stack movement and no error.
  assign do_push = push & ~pop & ~stack_full;
  assign do_pop  = pop & ~push & ~stack_empty;
  assign ovf_evt = push & ~pop & stack_full;
  assign unf_evt = pop & ~push & stack_empty;

  assign wr_idx = IDX_W'(depth_cnt);
  assign rd_idx = IDX_W'(depth_cnt - CNT_W'(1));

  // Oldest stage applied first so younger stages overwrite per bit.
  always_comb begin
    current_flags = ccr_reg;
    for (int unsigned b = 0; b < FLAG_W; b++) begin
      if (wb_mask[b]) current_flags[b] = wb_flags[b];
      for (int unsigned k = 0; k < N_FWD; k++) begin
        if (fwd_mask[(N_FWD-1-k)*FLAG_W + b])
          current_flags[b] = fwd_flags[(N_FWD-1-k)*FLAG_W + b];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && do_push) stack_mem[wr_idx] <= merged;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ccr_reg   <= '0;
      depth_cnt <= '0;
      ovf_err   <= 1'b0;
      unf_err   <= 1'b0;
    end else begin
      ccr_reg <= do_pop ? stack_mem[rd_idx] : merged;
      if (do_push)     depth_cnt <= depth_cnt + CNT_W'(1);
      else if (do_pop) depth_cnt <= depth_cnt - CNT_W'(1);
`ifdef CCR_STACK_STICKY_ERR_EN
      ovf_err <= ovf_evt | (ovf_err & ~err_clr);
      unf_err <= unf_evt | (unf_err & ~err_clr);
`else
      ovf_err <= ovf_evt;
      unf_err <= unf_evt;
`endif
    end
  end

`ifndef CCR_STACK_STICKY_ERR_EN
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
`endif

endmodule

// File: tb/tb_ccr_stack_unit.sv
// Scoreboard bench for ccr_stack_unit: stimulus queues expected values, a negedge monitor checks them.
module tb_ccr_stack_unit;

`ifdef CCR_STACK_STICKY_ERR_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  localparam int F_CCR = 0, F_CUR = 1, F_DEP = 2, F_FULL = 3, F_EMPTY = 4, F_OVF = 5, F_UNF = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] fwd_flags, fwd_mask;
  logic [3:0] wb_flags, wb_mask;
  logic       push, pop, err_clr;
  logic [3:0] ccr_reg, current_flags;
  logic [2:0] depth_cnt;
  logic       stack_full, stack_empty, ovf_err, unf_err;

  ccr_stack_unit #(.FLAG_W(4), .N_FWD(2), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .fwd_flags(fwd_flags), .fwd_mask(fwd_mask),
    .wb_flags(wb_flags), .wb_mask(wb_mask), .push(push), .pop(pop), .err_clr(err_clr),
    .ccr_reg(ccr_reg), .current_flags(current_flags), .depth_cnt(depth_cnt),
    .stack_full(stack_full), .stack_empty(stack_empty), .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    int         field;
    logic [7:0] val;
    int         due;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  function automatic logic [7:0] actual(input int f);
    case (f)
      F_CCR:   return {4'b0, ccr_reg};
      F_CUR:   return {4'b0, current_flags};
      F_DEP:   return {5'b0, depth_cnt};
      F_FULL:  return {7'b0, stack_full};
      F_EMPTY: return {7'b0, stack_empty};
      F_OVF:   return {7'b0, ovf_err};
      default: return {7'b0, unf_err};
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].due <= cyc) begin
        checks++;
        if (q[i].due < cyc) begin
          failures++;
          $display("FAIL %s: check missed its cycle (due %0d, now %0d)", q[i].name, q[i].due, cyc);
        end else if (actual(q[i].field) !== q[i].val) begin
          failures++;
          $display("FAIL %s: got %b expected %b (cycle %0d)", q[i].name,
                   actual(q[i].field), q[i].val, cyc);
        end
        q.delete(i);
      end
    end
  end

  task automatic expect_v(input string n, input int f, input logic [7:0] v, input int d);
    q.push_back('{name: n, field: f, val: v, due: cyc + d});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ps, input logic pp, input logic [3:0] wf, input logic [3:0] wm);
    push = ps; pop = pp; wb_flags = wf; wb_mask = wm;
    fwd_flags = '0; fwd_mask = '0; err_clr = 1'b0;
  endtask

  task automatic expect_reset(input string tag, input int d);
    expect_v({tag, "_ccr"},   F_CCR,   8'h0, d);
    expect_v({tag, "_depth"}, F_DEP,   8'h0, d);
    expect_v({tag, "_empty"}, F_EMPTY, 8'h1, d);
    expect_v({tag, "_full"},  F_FULL,  8'h0, d);
    expect_v({tag, "_ovf"},   F_OVF,   8'h0, d);
    expect_v({tag, "_unf"},   F_UNF,   8'h0, d);
  endtask

  logic [3:0] vals [4];

  initial begin
    vals[0] = 4'b0001; vals[1] = 4'b0010; vals[2] = 4'b0100; vals[3] = 4'b1000;
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 4'h0);
    tick();
    expect_reset("reset", 0);
    tick();
    rst = 1'b1;

    // forward priority: bits 1:0 from stage 0, bits 3:2 from stage 1
    fwd_flags = {4'b1110, 4'b0001};
    fwd_mask  = {4'b1111, 4'b0011};
    expect_v("fwd_priority", F_CUR, 8'b1101, 0);
    expect_v("fwd_no_commit", F_CCR, 8'b0000, 1);
    tick();

    // write-back forwarding, partial mask
    drive(1'b0, 1'b0, 4'b1010, 4'b1100);
    expect_v("fwd_wb", F_CUR, 8'b1000, 0);
    expect_v("commit_partial", F_CCR, 8'b1000, 1);
    tick();
    drive(1'b0, 1'b0, 4'b1010, 4'b1111);
    expect_v("commit_full", F_CCR, 8'b1010, 1);
    tick();

    // masked commit
    drive(1'b0, 1'b0, 4'b0101, 4'b0011);
    expect_v("masked_cur", F_CUR, 8'b1001, 0);
    expect_v("masked_commit", F_CCR, 8'b1001, 1);
    tick();

    // push/pop round trip
    drive(1'b0, 1'b0, 4'b0110, 4'b1111);
    tick();
    drive(1'b1, 1'b0, 4'b0000, 4'b0000);
    expect_v("rt_push_depth", F_DEP, 8'd1, 1);
    tick();
    drive(1'b0, 1'b0, 4'b1111, 4'b1111);
    expect_v("rt_commit", F_CCR, 8'b1111, 1);
    tick();
    drive(1'b0, 1'b1, 4'b0000, 4'b1111);
    expect_v("rt_pop_cur_ignores_pop", F_CUR, 8'b0000, 0);
    expect_v("rt_pop_ccr", F_CCR, 8'b0110, 1);
    expect_v("rt_pop_depth", F_DEP, 8'd0, 1);
    tick();

    // overflow: five pushes, each saving the value committed that cycle
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, (i < 4) ? vals[i] : 4'b1111, 4'b1111);
      if (i == 3) expect_v("ovf_full_at4", F_FULL, 8'h1, 1);
      if (i == 3) expect_v("ovf_none_at4", F_OVF, 8'h0, 1);
      tick();
    end
    expect_v("ovf_depth", F_DEP, 8'd4, 0);
    expect_v("ovf_full", F_FULL, 8'h1, 0);
    expect_v("ovf_err", F_OVF, 8'h1, 0);
    expect_v("ovf_ccr", F_CCR, 8'b1111, 0);
    for (int i = 3; i >= 0; i--) begin
      drive(1'b0, 1'b1, 4'h0, 4'h0);
      expect_v($sformatf("lifo_pop%0d", 3 - i), F_CCR, {4'b0, vals[i]}, 1);
      expect_v($sformatf("lifo_depth%0d", 3 - i), F_DEP, 8'(i), 1);
      if (i == 3) expect_v("ovf_after", F_OVF, {7'b0, STICKY}, 1);
      tick();
    end
    expect_v("lifo_empty", F_EMPTY, 8'h1, 0);

    // underflow: ccr 0001 merged with wb 0101/0110 -> 0101
    drive(1'b0, 1'b1, 4'b0101, 4'b0110);
    expect_v("unf_err", F_UNF, 8'h1, 1);
    expect_v("unf_ccr", F_CCR, 8'b0101, 1);
    expect_v("unf_depth", F_DEP, 8'd0, 1);
    tick();
    drive(1'b0, 1'b0, 4'h0, 4'h0);
    err_clr = 1'b1;
    expect_v("clr_ovf", F_OVF, 8'h0, 1);
    expect_v("clr_unf", F_UNF, 8'h0, 1);
    tick();

    // simultaneous push+pop at depth 2
    drive(1'b1, 1'b0, 4'h0, 4'h0);
    tick();
    tick();
    drive(1'b1, 1'b1, 4'b0011, 4'b1111);
    expect_v("both_depth", F_DEP, 8'd2, 1);
    expect_v("both_ccr", F_CCR, 8'b0011, 1);
    expect_v("both_ovf", F_OVF, 8'h0, 1);
    expect_v("both_unf", F_UNF, 8'h0, 1);
    tick();

    // reset mid-operation, with a push in flight
    drive(1'b1, 1'b0, 4'h0, 4'h0);
    expect_v("pre_rst_depth", F_DEP, 8'd3, 1);
    tick();
    drive(1'b1, 1'b0, 4'b1111, 4'b1111);
    rst = 1'b0;
    expect_reset("midrst", 1);
    tick();
    rst = 1'b1;
    drive(1'b0, 1'b1, 4'h0, 4'h0);
    expect_v("post_rst_unf", F_UNF, 8'h1, 1);
    expect_v("post_rst_depth", F_DEP, 8'd0, 1);
    tick();
    drive(1'b0, 1'b0, 4'h0, 4'h0);

    repeat (3) @(negedge clk);
    #1;
    while (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL %s: never checked (due %0d)", q[0].name, q[0].due);
      void'(q.pop_front());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
